// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM slot scheme: slot encodings, channel count,
// the legal slot rotation and the rotation-checker state type. The slot cycler
// on the transmit side imports this same package so both ends agree.
package tdm_pkg;

    localparam int NUM_CH = 3;

    localparam logic [1:0] SLOT_CH0 = 2'b10;
    localparam logic [1:0] SLOT_CH1 = 2'b01;
    localparam logic [1:0] SLOT_CH2 = 2'b00;
    localparam logic [1:0] SLOT_BAD = 2'b11;

    typedef enum logic {
        UNSYNC,
        LOCK
    } chk_state_t;

    // Successor in the legal rotation 10 -> 01 -> 00 -> 10.
    // The illegal encoding has no successor and maps to itself.
    function automatic logic [1:0] succ(input logic [1:0] slot);
        case (slot)
            SLOT_CH0: return SLOT_CH1;
            SLOT_CH1: return SLOT_CH2;
            SLOT_CH2: return SLOT_CH0;
            default:  return SLOT_BAD;
        endcase
    endfunction

    function automatic logic slot_legal(input logic [1:0] slot);
        return slot != SLOT_BAD;
    endfunction

    // Slot encoding that addresses a given channel index.
    function automatic logic [1:0] ch_slot(input int unsigned ch);
        case (ch)
            0:       return SLOT_CH0;
            1:       return SLOT_CH1;
            default: return SLOT_CH2;
        endcase
    endfunction

endpackage

// File: rtl/tdm_fifo.sv
// Per-channel receive FIFO. A push is accepted when there is room, or when
// the FIFO is full but a pop frees an entry in the same cycle. Pushes that
// cannot be accepted are silently ignored; the parent detects that case.
module tdm_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             data_in,
    input  logic                     pop,
    output logic [W-1:0]             data_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign data_out = mem[rd_ptr];

    // Storage array carries no reset; an empty count makes its contents irrelevant.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Receive endpoint of the TDM interconnect: decodes the slot select, steers
// valid beats into one FIFO per channel, tracks sticky overflow, and checks
// that the select follows the legal rotation.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           s,
    input  logic                 bus_valid,
    input  logic [W-1:0]         bus_data,
    output logic [NUM_CH*W-1:0]  out_data,
    output logic [NUM_CH-1:0]    out_valid,
    input  logic [NUM_CH-1:0]    out_ready,
    output logic                 locked,
    output logic                 seq_err,
    output logic [NUM_CH-1:0]    ovf
);

    logic [NUM_CH-1:0] push_req;
    logic [NUM_CH-1:0] pop_req;
    logic [NUM_CH-1:0] drop;

    chk_state_t state;
    chk_state_t state_nxt;
    logic [1:0] expected;
    logic [1:0] expected_nxt;
    logic       seq_err_nxt;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [$clog2(DEPTH):0] fifo_count;
        logic                   fifo_full;
        logic                   fifo_empty;

        // Steering ignores the checker, so a misrotated legal slot still routes.
        assign push_req[c]  = bus_valid && (s == ch_slot(c));
        assign pop_req[c]   = out_ready[c] && (fifo_count != '0);
        assign out_valid[c] = !fifo_empty;
        assign drop[c]      = push_req[c] && fifo_full && !pop_req[c];

        tdm_fifo #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (push_req[c]),
            .data_in  (bus_data),
            .pop      (pop_req[c]),
            .data_out (out_data[c*W +: W]),
            .count    (fifo_count),
            .full     (fifo_full),
            .empty    (fifo_empty)
        );
    end

    // Overflow flags are sticky until reset; illegal slots never reach a FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= '0;
        end else begin
            ovf <= ovf | drop;
        end
    end

    // Rotation checker registers: state, expected next slot, error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= UNSYNC;
            expected <= SLOT_CH0;
            seq_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            expected <= expected_nxt;
            seq_err  <= seq_err_nxt;
        end
    end

    // Rotation checker next-state: lock on any legal slot, resync on misrotation.
    always_comb begin
        state_nxt    = state;
        expected_nxt = expected;
        seq_err_nxt  = 1'b0;
        case (state)
            UNSYNC: begin
                if (slot_legal(s)) begin
                    state_nxt    = LOCK;
                    expected_nxt = succ(s);
                end
            end
            LOCK: begin
                if (!slot_legal(s)) begin
                    state_nxt   = UNSYNC;
                    seq_err_nxt = 1'b1;
                end else begin
                    expected_nxt = succ(s);
                    if (s != expected) begin
                        seq_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = UNSYNC;
            end
        endcase
    end

    assign locked = (state == LOCK);

endmodule
